dev_bus_ctrl: RTL and testbench

- Sequencing controller between the MEM-stage device port (Pr* bus) and two memory-mapped peripherals: device 0 at byte addresses 0x7f00–0x7f0b, device 1 at 0x7f10–0x7f1b.
- Decodes each device access, runs a req/ack handshake with the selected device and stalls the pipeline until the access completes or times out.
- Also aggregates device and external interrupt lines into the HWInt vector consumed by CP0.

---
 rtl/dev_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_dev_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dev_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dev_bus_ctrl
// Brief   : Pr* bus bridge to two memory-mapped devices with req/ack
//           handshake, pipeline stall, timeout bus error and HWInt aggregation.
// Revision: 1.0 - initial release
// ============================================================================
module dev_bus_ctrl #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7f10,
    parameter logic [31:0] DEV_SPAN  = 32'd12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] PrAddr,
    input  logic [3:0]  PrBE,
    input  logic [31:0] PrWD,
    input  logic        PrWE,
    input  logic        PrRE,
    output logic [31:0] PrRD,
    output logic        Pr_Stall,
    output logic        Pr_BusErr,
    output logic [1:0]  DevAddr,
    output logic [31:0] DevWD,
    output logic [3:0]  DevBE,
    output logic        DevWE,
    output logic        Dev0_Req,
    output logic        Dev1_Req,
    input  logic        Dev0_Ack,
    input  logic        Dev1_Ack,
    input  logic [31:0] Dev0_RD,
    input  logic [31:0] Dev1_RD,
    input  logic        Dev0_IRQ,
    input  logic        Dev1_IRQ,
    input  logic [3:0]  Ext_Int,
    output logic [5:0]  HWInt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int          c_CW       = $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT - 1);

    // Word-address windows derived from the inclusive byte ranges
    localparam logic [31:0] c_DEV0_END = DEV0_BASE + DEV_SPAN - 32'd1;
    localparam logic [31:0] c_DEV1_END = DEV1_BASE + DEV_SPAN - 32'd1;
    localparam logic [29:0] c_DEV0_LO  = DEV0_BASE[31:2];
    localparam logic [29:0] c_DEV0_HI  = c_DEV0_END[31:2];
    localparam logic [29:0] c_DEV1_LO  = DEV1_BASE[31:2];
    localparam logic [29:0] c_DEV1_HI  = c_DEV1_END[31:2];

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic            r_sel;
    logic [31:0]     r_rdata;
    logic [1:0]      r_dev_addr;
    logic [31:0]     r_dev_wd;
    logic [3:0]      r_dev_be;
    logic            r_dev_we;
    logic            r_req0;
    logic            r_req1;
    logic [3:0]      r_ext_int;

    logic w_hit0;
    logic w_hit1;
    logic w_start;
    logic w_sel_ack;
    logic w_timeout;

    assign w_hit0    = (PrAddr >= c_DEV0_LO) && (PrAddr <= c_DEV0_HI);
    assign w_hit1    = (PrAddr >= c_DEV1_LO) && (PrAddr <= c_DEV1_HI);
    assign w_start   = (PrWE | PrRE) & (w_hit0 | w_hit1);
    // Only the selected device's ack counts; the other one is ignored
    assign w_sel_ack = r_sel ? Dev1_Ack : Dev0_Ack;
    assign w_timeout = (r_cnt == c_TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_REQ;
            S_REQ: begin
                if (w_sel_ack)      w_state_nxt = S_DONE;
                else if (w_timeout) w_state_nxt = S_ERR;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= 1'b0;
            r_rdata    <= '0;
            r_dev_addr <= '0;
            r_dev_wd   <= '0;
            r_dev_be   <= '0;
            r_dev_we   <= 1'b0;
            r_req0     <= 1'b0;
            r_req1     <= 1'b0;
            r_ext_int  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ext_int <= Ext_Int;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_dev_addr <= PrAddr[1:0];
                        r_dev_wd   <= PrWD;
                        r_dev_be   <= PrBE;
                        r_dev_we   <= PrWE;
                        r_sel      <= w_hit1;
                        r_cnt      <= '0;
                        r_req0     <= w_hit0;
                        r_req1     <= w_hit1;
                    end
                end
                S_REQ: begin
                    if (w_sel_ack) begin
                        r_rdata <= r_dev_we ? 32'd0 : (r_sel ? Dev1_RD : Dev0_RD);
                        r_req0  <= 1'b0;
                        r_req1  <= 1'b0;
                    end else if (w_timeout) begin
                        r_req0  <= 1'b0;
                        r_req1  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + c_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Pr_Stall  = !reset && (((r_state == S_IDLE) && w_start) || (r_state == S_REQ));
    assign Pr_BusErr = (r_state == S_ERR);
    assign PrRD      = (r_state == S_DONE) ? r_rdata : 32'd0;
    assign DevAddr   = r_dev_addr;
    assign DevWD     = r_dev_wd;
    assign DevBE     = r_dev_be;
    assign DevWE     = r_dev_we;
    assign Dev0_Req  = r_req0;
    assign Dev1_Req  = r_req1;
    assign HWInt     = {r_ext_int, Dev1_IRQ, Dev0_IRQ};

endmodule
`default_nettype wire

// File: tb/tb_dev_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dev_bus_ctrl
// Brief   : Directed self-checking bench for dev_bus_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dev_bus_ctrl;

    logic        clk;
    logic        reset;
    logic [29:0] PrAddr;
    logic [3:0]  PrBE;
    logic [31:0] PrWD;
    logic        PrWE;
    logic        PrRE;
    logic [31:0] PrRD;
    logic        Pr_Stall;
    logic        Pr_BusErr;
    logic [1:0]  DevAddr;
    logic [31:0] DevWD;
    logic [3:0]  DevBE;
    logic        DevWE;
    logic        Dev0_Req;
    logic        Dev1_Req;
    logic        Dev0_Ack;
    logic        Dev1_Ack;
    logic [31:0] Dev0_RD;
    logic [31:0] Dev1_RD;
    logic        Dev0_IRQ;
    logic        Dev1_IRQ;
    logic [3:0]  Ext_Int;
    logic [5:0]  HWInt;

    int n_checks;
    int n_errors;
    int n_req;
    int n_berr;

    dev_bus_ctrl #(.TIMEOUT(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .PrAddr    (PrAddr),
        .PrBE      (PrBE),
        .PrWD      (PrWD),
        .PrWE      (PrWE),
        .PrRE      (PrRE),
        .PrRD      (PrRD),
        .Pr_Stall  (Pr_Stall),
        .Pr_BusErr (Pr_BusErr),
        .DevAddr   (DevAddr),
        .DevWD     (DevWD),
        .DevBE     (DevBE),
        .DevWE     (DevWE),
        .Dev0_Req  (Dev0_Req),
        .Dev1_Req  (Dev1_Req),
        .Dev0_Ack  (Dev0_Ack),
        .Dev1_Ack  (Dev1_Ack),
        .Dev0_RD   (Dev0_RD),
        .Dev1_RD   (Dev1_RD),
        .Dev0_IRQ  (Dev0_IRQ),
        .Dev1_IRQ  (Dev1_IRQ),
        .Ext_Int   (Ext_Int),
        .HWInt     (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        PrAddr = '0; PrBE = '0; PrWD = '0; PrWE = 1'b0; PrRE = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1'b1;
        bus_idle();
        Dev0_Ack = 0; Dev1_Ack = 0; Dev0_RD = '0; Dev1_RD = '0;
        Dev0_IRQ = 0; Dev1_IRQ = 0; Ext_Int = '0;
        repeat (2) cyc();
        reset = 1'b0;
        smp();
        check("rst_stall", 32'(Pr_Stall), 0);
        check("rst_req",   32'({Dev1_Req, Dev0_Req}), 0);
        check("rst_prrd",  PrRD, 0);
        check("rst_hwint", 32'(HWInt), 0);
        check("rst_latch", 32'({DevAddr, DevBE, DevWE}), 0);

        // Read dev0 offset 1, ack in first REQ cycle
        cyc(); PrAddr = 30'h1FC1; PrRE = 1'b1;
        smp();
        check("rd_idle_stall", 32'(Pr_Stall), 1);
        check("rd_idle_req",   32'(Dev0_Req), 0);
        cyc(); Dev0_Ack = 1'b1; Dev0_RD = 32'h1234;
        smp();
        check("rd_req_stall", 32'(Pr_Stall), 1);
        check("rd_req0",      32'(Dev0_Req), 1);
        check("rd_req1",      32'(Dev1_Req), 0);
        check("rd_devaddr",   32'(DevAddr), 1);
        check("rd_devwe",     32'(DevWE), 0);
        cyc(); Dev0_Ack = 1'b0; Dev0_RD = 32'h0;
        smp();
        check("rd_done_stall", 32'(Pr_Stall), 0);
        check("rd_done_prrd",  PrRD, 32'h1234);
        check("rd_done_req",   32'({Dev1_Req, Dev0_Req}), 0);
        cyc(); bus_idle();
        smp();
        check("rd_after_prrd", PrRD, 0);
        cyc();
        smp();
        check("rd_no_reissue", 32'({Pr_Stall, Dev1_Req, Dev0_Req}), 0);

        // Write dev1 offset 2, ack on third REQ cycle
        cyc(); PrAddr = 30'h1FC6; PrWE = 1'b1; PrWD = 32'hDEADBEEF; PrBE = 4'hF;
        Dev1_RD = 32'h55AA55AA;
        smp();
        check("wr_idle_stall", 32'(Pr_Stall), 1);
        n_req = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); Dev1_Ack = (i == 2);
            smp();
            if (Dev1_Req && Pr_Stall && !Dev0_Req) n_req++;
        end
        check("wr_req_cycles", 32'(n_req), 3);
        check("wr_devwd",   DevWD, 32'hDEADBEEF);
        check("wr_latches", 32'({DevAddr, DevBE, DevWE}), 32'({2'd2, 4'hF, 1'b1}));
        cyc(); Dev1_Ack = 1'b0;
        smp();
        check("wr_done_stall", 32'(Pr_Stall), 0);
        check("wr_done_prrd",  PrRD, 0);
        check("wr_done_req",   32'(Dev1_Req), 0);
        cyc(); bus_idle(); Dev1_RD = '0;
        smp();
        check("wr_one_episode", 32'({Pr_Stall, Dev1_Req}), 0);

        // Misses: gap word 0x7f0c and plain data memory
        cyc(); PrAddr = 30'h1FC3; PrRE = 1'b1;
        smp();
        check("miss_gap_stall", 32'(Pr_Stall), 0);
        cyc();
        smp();
        check("miss_gap_req", 32'({Dev1_Req, Dev0_Req}), 0);
        check("miss_gap_prrd", PrRD, 0);
        cyc(); PrAddr = 30'h0010; PrRE = 1'b0; PrWE = 1'b1;
        smp();
        check("miss_dm_stall", 32'(Pr_Stall), 0);
        cyc();
        smp();
        check("miss_dm_req", 32'({Dev1_Req, Dev0_Req}), 0);
        cyc(); bus_idle();

        // Timeout on dev0
        cyc(); PrAddr = 30'h1FC0; PrRE = 1'b1; Dev0_RD = 32'hFFFF_0000;
        smp();
        check("to_idle_stall", 32'(Pr_Stall), 1);
        n_req = 0; n_berr = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            smp();
            if (Dev0_Req && Pr_Stall) n_req++;
            if (Pr_BusErr) n_berr++;
        end
        check("to_req_cycles", 32'(n_req), 16);
        check("to_early_berr", 32'(n_berr), 0);
        cyc();
        smp();
        check("to_berr",  32'(Pr_BusErr), 1);
        check("to_stall", 32'(Pr_Stall), 0);
        check("to_prrd",  PrRD, 0);
        check("to_req",   32'(Dev0_Req), 0);
        cyc(); bus_idle(); Dev0_RD = '0;
        smp();
        check("to_berr_pulse", 32'({Pr_BusErr, Pr_Stall, Dev0_Req}), 0);

        // Spurious Dev1 ack during dev0 access, then reset mid-REQ
        cyc(); PrAddr = 30'h1FC2; PrRE = 1'b1;
        smp();
        cyc(); Dev1_Ack = 1'b1;
        smp();
        check("sp_req0", 32'({Pr_Stall, Dev0_Req, Dev1_Req}), 32'b110);
        cyc(); Dev1_Ack = 1'b0;
        smp();
        check("sp_ignored", 32'({Pr_Stall, Dev0_Req}), 32'b11);
        check("sp_prrd", PrRD, 0);
        cyc(); reset = 1'b1; bus_idle();
        cyc(); reset = 1'b0;
        smp();
        check("rstreq_req",   32'({Dev1_Req, Dev0_Req}), 0);
        check("rstreq_stall", 32'(Pr_Stall), 0);
        check("rstreq_pulse", 32'({Pr_BusErr, PrRD != 0}), 0);
        cyc();
        smp();
        check("rstreq_idle", 32'({Pr_BusErr, Pr_Stall, Dev0_Req, PrRD != 0}), 0);

        // Interrupt aggregation
        cyc(); Ext_Int = 4'b1010; Dev1_IRQ = 1'b1;
        smp();
        check("irq_now",   32'(HWInt), 32'b000010);
        cyc();
        smp();
        check("irq_delay", 32'(HWInt), 32'b101010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
